// File: rtl/arb_mux16_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arb_mux_pkg
// Purpose  : Shared constants and enums for the arb_mux16 arbitrating mux.
// Revision : 1.0  initial release
// ============================================================================
package arb_mux_pkg;

    localparam int c_default_width = 16;
    localparam int c_default_n     = 8;

    typedef enum logic [0:0] {
        PRIO_RR    = 1'b0,
        PRIO_FIXED = 1'b1
    } prio_mode_e;

    typedef enum logic [0:0] {
        LK_IDLE   = 1'b0,
        LK_LOCKED = 1'b1
    } lock_state_e;

endpackage
`default_nettype wire

// File: rtl/arb_mux16_if.sv
`default_nettype none
// ============================================================================
// Module   : arb_mux16_if
// Purpose  : Request/response bundle for arb_mux16; in_last only exists when
//            ARB_MUX_LOCK_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
interface arb_mux16_if
    import arb_mux_pkg::*;
#(
    parameter int WIDTH = c_default_width,
    parameter int N     = c_default_n,
    parameter int SELW  = $clog2(N)
);
    logic                 prio_mode;
    logic [N-1:0]         in_valid;
    logic [N*WIDTH-1:0]   in_data;
    logic [N-1:0]         in_ready;
    logic                 out_valid;
    logic [WIDTH-1:0]     out_data;
    logic [SELW-1:0]      out_sel;
    logic                 out_ready;
`ifdef ARB_MUX_LOCK_EN
    logic [N-1:0]         in_last;
`endif

    modport master (
        output prio_mode, in_valid, in_data, out_ready,
`ifdef ARB_MUX_LOCK_EN
        output in_last,
`endif
        input  in_ready, out_valid, out_data, out_sel
    );

    modport slave (
        input  prio_mode, in_valid, in_data, out_ready,
`ifdef ARB_MUX_LOCK_EN
        input  in_last,
`endif
        output in_ready, out_valid, out_data, out_sel
    );

endinterface
`default_nettype wire

// File: rtl/arb_mux16_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational rotating priority encoder; searches from i_start
//            upward (wrapping), or from index 0 when i_fixed is set.
// Revision : 1.0  initial release
// ============================================================================
module rr_pick #(
    parameter int N    = 8,
    parameter int SELW = $clog2(N)
) (
    input  wire logic [N-1:0]    i_req,
    input  wire logic [SELW-1:0] i_start,
    input  wire logic            i_fixed,
    output logic      [N-1:0]    o_gnt,
    output logic      [SELW-1:0] o_idx,
    output logic                 o_any
);

    always_comb begin : p_pick
        int v_base;
        int v_ch;
        v_base = i_fixed ? 0 : int'(i_start);
        v_ch   = 0;
        o_gnt  = '0;
        o_idx  = '0;
        o_any  = 1'b0;
        for (int k = 0; k < N; k++) begin
            v_ch = v_base + k;
            if (v_ch >= N) begin
                v_ch = v_ch - N;
            end
            if (!o_any && i_req[v_ch]) begin
                o_any       = 1'b1;
                o_gnt[v_ch] = 1'b1;
                o_idx       = SELW'(v_ch);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/arb_mux16.sv
`default_nettype none
// ============================================================================
// Module   : arb_mux16
// Purpose  : Registered N-way arbitrating mux (round-robin / fixed priority).
//            Define ARB_MUX_LOCK_EN to hold a grant until in_last of a packet.
// Revision : 1.0  initial release
// ============================================================================
module arb_mux16
    import arb_mux_pkg::*;
#(
    parameter int WIDTH = c_default_width,
    parameter int N     = c_default_n,
    parameter int SELW  = $clog2(N)
) (
    input  wire logic  clk,
    input  wire logic  reset,
    arb_mux16_if.slave bus
);

    logic [N-1:0]     w_req;
    logic [N-1:0]     w_gnt;
    logic [SELW-1:0]  w_idx;
    logic             w_any;
    logic             w_fixed;
    logic             w_load;
    logic             w_xfer;
    logic [SELW-1:0]  w_start;
    logic [WIDTH-1:0] w_chan [N];

    logic             r_out_valid_q,  w_out_valid_d;
    logic [WIDTH-1:0] r_out_data_q,   w_out_data_d;
    logic [SELW-1:0]  r_out_sel_q,    w_out_sel_d;
    logic [SELW-1:0]  r_last_grant_q, w_last_grant_d;

    for (genvar i = 0; i < N; i++) begin : g_chan
        assign w_chan[i] = bus.in_data[i*WIDTH +: WIDTH];
    end

    assign w_start = (r_last_grant_q == SELW'(N-1)) ? '0 : r_last_grant_q + SELW'(1);
    assign w_load  = !r_out_valid_q || bus.out_ready;
    // Holding reset low suppresses every grant, so a word in flight is dropped.
    assign w_xfer  = reset && w_load && w_any;

`ifdef ARB_MUX_LOCK_EN
    lock_state_e     r_lock_state_q, w_lock_state_d;
    logic [SELW-1:0] r_lock_ch_q,    w_lock_ch_d;
    logic [N-1:0]    w_lock_mask;
    logic            w_locked;

    assign w_locked    = (r_lock_state_q == LK_LOCKED);
    assign w_lock_mask = {{(N-1){1'b0}}, 1'b1} << r_lock_ch_q;
    assign w_req       = w_locked ? (bus.in_valid & w_lock_mask) : bus.in_valid;
    assign w_fixed     = w_locked || (prio_mode_e'(bus.prio_mode) == PRIO_FIXED);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_lock_state_q <= LK_IDLE;
            r_lock_ch_q    <= '0;
        end else begin
            r_lock_state_q <= w_lock_state_d;
            r_lock_ch_q    <= w_lock_ch_d;
        end
    end

    always_comb begin
        w_lock_state_d = r_lock_state_q;
        w_lock_ch_d    = r_lock_ch_q;
        case (r_lock_state_q)
            LK_IDLE: begin
                // A single-beat packet never enters LOCKED.
                if (w_xfer && !bus.in_last[w_idx]) begin
                    w_lock_state_d = LK_LOCKED;
                    w_lock_ch_d    = w_idx;
                end
            end
            LK_LOCKED: begin
                if (w_xfer && bus.in_last[r_lock_ch_q]) begin
                    w_lock_state_d = LK_IDLE;
                end
            end
            default: begin
                w_lock_state_d = LK_IDLE;
            end
        endcase
    end
`else
    assign w_req   = bus.in_valid;
    assign w_fixed = (prio_mode_e'(bus.prio_mode) == PRIO_FIXED);
`endif

    rr_pick #(
        .N    (N),
        .SELW (SELW)
    ) u_pick (
        .i_req   (w_req),
        .i_start (w_start),
        .i_fixed (w_fixed),
        .o_gnt   (w_gnt),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    assign bus.in_ready = w_xfer ? w_gnt : '0;

    always_comb begin
        w_out_valid_d  = r_out_valid_q;
        w_out_data_d   = r_out_data_q;
        w_out_sel_d    = r_out_sel_q;
        w_last_grant_d = r_last_grant_q;
        if (w_xfer) begin
            w_out_valid_d  = 1'b1;
            w_out_data_d   = w_chan[w_idx];
            w_out_sel_d    = w_idx;
            w_last_grant_d = w_idx;
        end else if (w_load) begin
            // Drained with nothing to replace it: data and index keep their values.
            w_out_valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_out_valid_q  <= 1'b0;
            r_out_data_q   <= '0;
            r_out_sel_q    <= '0;
            r_last_grant_q <= SELW'(N-1);
        end else begin
            r_out_valid_q  <= w_out_valid_d;
            r_out_data_q   <= w_out_data_d;
            r_out_sel_q    <= w_out_sel_d;
            r_last_grant_q <= w_last_grant_d;
        end
    end

    assign bus.out_valid = r_out_valid_q;
    assign bus.out_data  = r_out_data_q;
    assign bus.out_sel   = r_out_sel_q;

endmodule
`default_nettype wire

// File: tb/tb_arb_mux16.sv
`default_nettype none
// ============================================================================
// Module   : tb_arb_mux16
// Purpose  : Self-checking bench for arb_mux16 (N=8/16-bit and N=4/32-bit).
// Revision : 1.0  initial release
// ============================================================================
module tb_arb_mux16;
    import arb_mux_pkg::*;

    localparam int N     = 8;
    localparam int WIDTH = 16;

    logic clk = 1'b0;
    logic reset;
    logic reset4;

    always #5 clk = ~clk;

    arb_mux16_if #(.WIDTH(WIDTH), .N(N)) bus ();
    arb_mux16 #(.WIDTH(WIDTH), .N(N)) dut (.clk(clk), .reset(reset), .bus(bus));

    arb_mux16_if #(.WIDTH(32), .N(4)) bus4 ();
    arb_mux16 #(.WIDTH(32), .N(4)) dut4 (.clk(clk), .reset(reset4), .bus(bus4));

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, got, exp);
    endtask

    // Reference model: state of the output register, rotation pointer and packet lock.
    bit               m_ov    = 1'b0;
    logic [WIDTH-1:0] m_data  = '0;
    int               m_sel   = 0;
    int               m_last  = N-1;
    bit               m_lock  = 1'b0;
    int               m_ch    = 0;

    task automatic model_eval(output logic [N-1:0] rdy, output int win);
        int best;
        int rank;
        rdy  = '0;
        win  = -1;
        best = N;
        if (!reset) return;
        if (m_ov && !bus.out_ready) return;
        for (int c = 0; c < N; c++) begin
            if (bus.in_valid[c] && (!m_lock || c == m_ch)) begin
                rank = (bus.prio_mode || m_lock) ? c : (c - m_last - 1 + 2*N) % N;
                if (rank < best) begin
                    best = rank;
                    win  = c;
                end
            end
        end
        if (win >= 0) rdy[win] = 1'b1;
    endtask

    task automatic model_advance(input int win);
        if (!reset) begin
            m_ov = 1'b0; m_data = '0; m_sel = 0; m_last = N-1; m_lock = 1'b0;
        end else if (!m_ov || bus.out_ready) begin
            if (win >= 0) begin
                m_ov   = 1'b1;
                m_data = bus.in_data[win*WIDTH +: WIDTH];
                m_sel  = win;
                m_last = win;
`ifdef ARB_MUX_LOCK_EN
                if (!m_lock && !bus.in_last[win]) begin
                    m_lock = 1'b1;
                    m_ch   = win;
                end else if (m_lock && bus.in_last[win]) begin
                    m_lock = 1'b0;
                end
`endif
            end else begin
                m_ov = 1'b0;
            end
        end
    endtask

    // Inputs must already be applied; returns at posedge+1.
    task automatic run_cycle(output logic [N-1:0] got_rdy, output logic [N-1:0] exp_rdy);
        int win;
        #3;
        got_rdy = bus.in_ready;
        model_eval(exp_rdy, win);
        @(posedge clk);
        model_advance(win);
        #1;
    endtask

    typedef struct {
        bit          rst_n;
        bit          prio;
        logic [7:0]  valid;
        logic [7:0]  last;
        bit          ordy;
        logic [7:0]  exp_rdy;
        bit          exp_ov;
        logic [2:0]  exp_sel;
        logic [15:0] exp_data;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit rst_n, input bit prio, input logic [7:0] valid,
                       input logic [7:0] last, input bit ordy, input logic [7:0] exp_rdy,
                       input bit exp_ov, input logic [2:0] exp_sel, input logic [15:0] exp_data);
        vec_t v;
        v.rst_n = rst_n; v.prio = prio; v.valid = valid; v.last = last; v.ordy = ordy;
        v.exp_rdy = exp_rdy; v.exp_ov = exp_ov; v.exp_sel = exp_sel; v.exp_data = exp_data;
        vecs.push_back(v);
    endtask

    initial begin
        logic [N-1:0] gr;
        logic [N-1:0] er;

        // Reset with everyone requesting, then a full round-robin lap.
        add(0, 0, 8'hFF, 8'hFF, 1, 8'h00, 0, 3'd0, 16'h0000);
        add(0, 0, 8'hFF, 8'hFF, 1, 8'h00, 0, 3'd0, 16'h0000);
        for (int i = 0; i < 9; i++)
            add(1, 0, 8'hFF, 8'hFF, 1, 8'(1 << (i % 8)), 1, 3'(i % 8), 16'hA000 + 16'(i % 8));
        // Fixed priority, lowest valid index (2) wins every cycle.
        for (int i = 0; i < 3; i++)
            add(1, 1, 8'hA4, 8'hFF, 1, 8'h04, 1, 3'd2, 16'hA002);
        // Round-robin 3 and 5 with a 4-cycle downstream stall.
        add(1, 0, 8'h28, 8'hFF, 1, 8'h08, 1, 3'd3, 16'hA003);
        for (int i = 0; i < 4; i++)
            add(1, 0, 8'h28, 8'hFF, 0, 8'h00, 1, 3'd3, 16'hA003);
        add(1, 0, 8'h28, 8'hFF, 1, 8'h20, 1, 3'd5, 16'hA005);
        add(1, 0, 8'h28, 8'hFF, 1, 8'h08, 1, 3'd3, 16'hA003);
        // No requests: valid drops, data and index hold.
        add(1, 0, 8'h00, 8'hFF, 1, 8'h00, 0, 3'd3, 16'hA003);
        add(1, 0, 8'h00, 8'hFF, 0, 8'h00, 0, 3'd3, 16'hA003);
        // Reset in the middle of a stream drops the word.
        add(1, 0, 8'h01, 8'hFF, 1, 8'h01, 1, 3'd0, 16'hA000);
        add(0, 0, 8'hFF, 8'hFF, 1, 8'h00, 0, 3'd0, 16'h0000);
        add(1, 0, 8'hFF, 8'hFF, 1, 8'h01, 1, 3'd0, 16'hA000);
`ifdef ARB_MUX_LOCK_EN
        // Channel 2 three-beat packet with a gap while channel 0 keeps requesting.
        add(0, 0, 8'h05, 8'h00, 1, 8'h00, 0, 3'd0, 16'h0000);
        add(1, 0, 8'h05, 8'h01, 1, 8'h01, 1, 3'd0, 16'hA000);
        add(1, 0, 8'h05, 8'h01, 1, 8'h04, 1, 3'd2, 16'hA002);
        add(1, 0, 8'h05, 8'h01, 1, 8'h04, 1, 3'd2, 16'hA002);
        add(1, 0, 8'h01, 8'h01, 1, 8'h00, 0, 3'd2, 16'hA002);
        add(1, 0, 8'h05, 8'h05, 1, 8'h04, 1, 3'd2, 16'hA002);
        add(1, 0, 8'h05, 8'h05, 1, 8'h01, 1, 3'd0, 16'hA000);
        // Reset while locked returns to unlocked round-robin from channel 0.
        add(1, 0, 8'h05, 8'h01, 1, 8'h04, 1, 3'd2, 16'hA002);
        add(0, 0, 8'h05, 8'h01, 1, 8'h00, 0, 3'd0, 16'h0000);
        add(1, 0, 8'h05, 8'h05, 1, 8'h01, 1, 3'd0, 16'hA000);
`endif

        reset          = 1'b0;
        reset4         = 1'b0;
        bus.prio_mode  = 1'b0;
        bus.in_valid   = '0;
        bus.out_ready  = 1'b1;
        for (int c = 0; c < N; c++) bus.in_data[c*WIDTH +: WIDTH] = 16'hA000 + 16'(c);
        bus4.prio_mode = 1'b0;
        bus4.in_valid  = '0;
        bus4.out_ready = 1'b1;
        bus4.in_data   = {32'h3333_3333, 32'h2222_2222, 32'hDEAD_BEEF, 32'h1111_1111};
`ifdef ARB_MUX_LOCK_EN
        bus.in_last    = '1;
        bus4.in_last   = '1;
`endif
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            reset         = vecs[i].rst_n;
            bus.prio_mode = vecs[i].prio;
            bus.in_valid  = vecs[i].valid;
            bus.out_ready = vecs[i].ordy;
`ifdef ARB_MUX_LOCK_EN
            bus.in_last   = vecs[i].last;
`endif
            run_cycle(gr, er);
            chk($sformatf("vec%0d in_ready", i), 32'(gr), 32'(vecs[i].exp_rdy));
            chk($sformatf("vec%0d out_valid", i), 32'(bus.out_valid), 32'(vecs[i].exp_ov));
            chk($sformatf("vec%0d out_sel", i), 32'(bus.out_sel), 32'(vecs[i].exp_sel));
            chk($sformatf("vec%0d out_data", i), 32'(bus.out_data), 32'(vecs[i].exp_data));
        end

        // Randomized traffic against the reference model.
        for (int c = 0; c < 1500; c++) begin
            reset         = ($urandom_range(0, 60) != 0);
            bus.prio_mode = ($urandom_range(0, 3) == 0);
            bus.in_valid  = 8'($urandom) & (($urandom_range(0, 1) != 0) ? 8'hFF : 8'($urandom));
            bus.out_ready = ($urandom_range(0, 3) != 0);
`ifdef ARB_MUX_LOCK_EN
            bus.in_last   = 8'($urandom);
`endif
            for (int ch = 0; ch < N; ch++) bus.in_data[ch*WIDTH +: WIDTH] = 16'($urandom);
            run_cycle(gr, er);
            chk("rand in_ready", 32'(gr), 32'(er));
            chk("rand out_valid", 32'(bus.out_valid), 32'(m_ov));
            chk("rand out_sel", 32'(bus.out_sel), 32'(m_sel));
            chk("rand out_data", 32'(bus.out_data), 32'(m_data));
        end

        // N=4, WIDTH=32 instance: held in reset until now.
        bus4.in_valid = 4'b0010;
        #3;
        chk("n4 in_ready in reset", 32'(bus4.in_ready), 32'h0);
        chk("n4 out_valid in reset", 32'(bus4.out_valid), 32'h0);
        @(posedge clk);
        #1;
        reset4 = 1'b1;
        #3;
        chk("n4 in_ready", 32'(bus4.in_ready), 32'h2);
        @(posedge clk);
        #1;
        chk("n4 out_valid", 32'(bus4.out_valid), 32'h1);
        chk("n4 out_data", bus4.out_data, 32'hDEAD_BEEF);
        chk("n4 out_sel", 32'(bus4.out_sel), 32'h1);
        bus4.in_valid = 4'b0000;
        @(posedge clk);
        #1;
        chk("n4 idle out_valid", 32'(bus4.out_valid), 32'h0);
        chk("n4 idle out_data", bus4.out_data, 32'hDEAD_BEEF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/arb_mux16.md
# arb_mux16

Parametrised, registered N-way datapath multiplexer with per-channel valid/ready handshakes and built-in arbitration. It is the successor to the fixed 16-bit 8:1 combinational selector. Instead of taking an external select, it picks among requesting sources itself, either round-robin or fixed-priority. It registers the winning word with its source index, and it sits on shared internal buses such as the register-file writeback and the memory-request path.

## Interface
- WIDTH, 16, data width per channel
- N, 8, number of input channels (2..16)
- SELW, $clog2(N), width of the source-index output
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-low reset, sampled on rising edge of clk
- prio_mode  input  1  0 = round-robin, 1 = fixed priority (lowest index wins)
- in_valid  input  N  per-channel request
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_ready  output  N  per-channel accept, one-hot or zero
- out_valid  output  1  output register holds a word
- out_data  output  WIDTH  selected word
- out_sel  output  SELW  index of the channel that supplied out_data
- out_ready  input  1  downstream accept
- in_last  input  N  end-of-packet marker, present only with ARB_MUX_LOCK_EN

## Operation
- load = !out_valid || out_ready; arbitration occurs only when load = 1.
- Round-robin:
  - Search starts at (last_grant + 1) mod N and picks the first valid channel.
  - last_grant updates only on an actual transfer.
- Fixed priority: the lowest-index valid channel wins, and last_grant still updates.
- Grant g:
  - in_ready[g] = 1 when load = 1 and any in_valid is set.
  - All other in_ready are 0.
  - in_ready is combinational from in_valid, prio_mode, state and out_ready.
- On a transfer: out_data <= in_data[g], out_sel <= g, out_valid <= 1.
- If load = 1 and no channel is valid, then out_valid <= 0 and out_data/out_sel hold their previous values.
- If out_valid = 1 and out_ready = 0, the output holds and every in_ready = 0.
- prio_mode may change on any cycle and takes effect at the next arbitration.
- Channels with index ≥ N do not exist. Widths are exact, with no padding or truncation.

## Timing
- Reset values: out_valid = 0, out_data = 0, out_sel = 0, in_ready = 0 during reset, last_grant = N-1 (so channel 0 is first in round-robin), lock state IDLE.
- Latency: one cycle from the in_valid/in_ready transfer edge to out_valid.
- Throughput: one word per cycle while out_ready = 1.
- If reset is asserted mid-transfer, the output word is dropped and no in_ready is asserted in that cycle.
- If out_ready = 1 and a new request arrive in the same cycle, the drain and load happen on the same edge with no bubble.

## Configuration
- ARB_MUX_LOCK_EN defined:
  - The in_last port exists and a two-state FSM is added: IDLE and LOCKED(ch).
  - IDLE → LOCKED(g): a granted beat transfers with in_last[g] = 0.
  - LOCKED(ch): only channel ch is eligible, whatever prio_mode says. If in_valid[ch] = 0, load produces a bubble.
  - LOCKED → IDLE: a channel-ch beat with in_last[ch] = 1 transfers.
  - A single-beat packet (in_last = 1 on its first beat) stays in IDLE.
  - last_grant updates to ch when the packet ends.
- ARB_MUX_LOCK_EN undefined: in_last is absent, every beat is arbitrated independently, and there is no FSM.

## Structure
- Package arb_mux_pkg:
  - Default WIDTH/N constants.
  - Enum for prio_mode (PRIO_RR, PRIO_FIXED).
  - Lock-state enum (LK_IDLE, LK_LOCKED).
- Sub-module rr_pick: purely combinational N-bit rotating priority encoder.
  - Inputs: req, start index, fixed flag.
  - Outputs: one-hot grant, encoded index, any.
  - Instantiated once.

## Test plan
- Reset with all in_valid = 1 → in_ready = 0 during reset. After release with out_ready = 1, the grant sequence is 0, 1, 2, …, 7, 0 and out_sel follows one cycle later.
- prio_mode = 1, in_valid = 8'b1010_0100, out_ready = 1 → channel 2 is granted every cycle and out_data = in_data[2] each cycle.
- Round-robin, channels 3 and 5 valid, out_ready held 0 for 4 cycles after the first load → out_valid = 1, out_data stable and in_ready = 0 for those cycles. On release, channel 5 then channel 3 transfer back to back.
- N = 4, WIDTH = 32, channel 1 data 32'hDEAD_BEEF → out_data = 32'hDEAD_BEEF and out_sel = 2'd1 after one cycle.
- Lock build, channel 2 sends 3 beats (in_last on the 3rd) while channel 0 is valid throughout → beats from channel 2 are contiguous, channel 0 is granted next, and a 1-cycle in_valid[2] gap mid-packet produces an out_valid = 0 bubble.
- Reset asserted while LOCKED → FSM returns to IDLE, out_valid = 0, and the first grant after release is channel 0.
